seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a bank of NUM_DIGITS seven-segment digits.
//  It drives one shared hex-to-segment decoder and sequences the digit enables.
//  Non-overlapping gaps between digits prevent ghosting. Display data is double-buffered
//  (shadow -> active at frame boundary) so a frame never shows a mix of old and new values.

---
 rtl/seg7_scan_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS seven-segment digits.
// Sequences one-hot digit enables with dark gaps between digits and feeds a shared
// hex decoder. Display data is double-buffered: the writer loads a shadow register,
// and the shadow is copied into the active register only at a frame boundary.
// Ports:
//   CLOCK_50    in  system clock, rising edge
//   reset       in  synchronous active-high reset
//   en          in  scan enable, sampled only at the end of a digit slot
//   wr_valid    in  writer presents value_in
//   value_in    in  packed nibbles, [3:0] = digit 0
//   wr_ready    out shadow buffer free; write accepted on wr_valid & wr_ready
//   dig_hex     out nibble to the shared decoder
//   dig_blank   out 1 = segments forced dark
//   dig_sel     out one-hot digit enable, zero when idle or in a gap
//   frame_start out one-cycle pulse on the first cycle of digit 0
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES   = 500,
  parameter int unsigned LZB          = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      wr_valid,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  output logic                      wr_ready,
  output logic [3:0]                dig_hex,
  output logic                      dig_blank,
  output logic [NUM_DIGITS-1:0]     dig_sel,
  output logic                      frame_start
);

  localparam int unsigned DATA_W    = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_MAX   = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DWELL_LAST = (DWELL_CYCLES == 0) ? 0 : DWELL_CYCLES - 1;
  localparam int unsigned GAP_LAST   = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic [DATA_W-1:0]       active_q, active_d;
  logic                    pending_q, pending_d;

  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic [3:0]              dig_hex_q, dig_hex_d;
  logic                    dig_blank_q, dig_blank_d;
  logic                    frame_start_q, frame_start_d;
  logic                    wr_ready_q, wr_ready_d;

  logic                    accept;
  logic                    xfer;
  logic                    frame_begin;
  logic                    slot_end;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   lzb_vec;
  logic [3:0]              nib [NUM_DIGITS];

  assign wr_ready    = wr_ready_q;
  assign dig_hex     = dig_hex_q;
  assign dig_blank   = dig_blank_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_start_q;

  // Next-state: scan sequencing, double-buffer transfer and write handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    pending_d   = pending_q;
    xfer        = 1'b0;
    frame_begin = 1'b0;
    slot_end    = 1'b0;
    accept      = wr_valid & wr_ready_q;

    case (state_q)
      IDLE: begin
        xfer = pending_q;
        if (en) begin
          state_d     = SHOW;
          idx_d       = '0;
          cnt_d       = '0;
          frame_begin = 1'b1;
        end
      end
      SHOW: begin
        if (cnt_q == CNT_W'(DWELL_LAST)) begin
          if (GAP_CYCLES != 0) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            slot_end = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          slot_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of a digit slot: en is only looked at here so a digit is never cut short.
    if (slot_end) begin
      cnt_d = '0;
      if (!en) begin
        state_d = IDLE;
      end else if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        state_d     = SHOW;
        idx_d       = '0;
        xfer        = pending_q;
        frame_begin = 1'b1;
      end else begin
        state_d = SHOW;
        idx_d   = idx_q + IDX_W'(1);
      end
    end

    // Transfer uses the registered pending flag, so a write landing on a boundary waits a frame.
    if (xfer) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    all_zero = 1'b1;
    lzb_vec  = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      nib[i] = active_d[4*i +: 4];
    end
    // Scan from the top nibble down; a digit blanks while everything above it is zero.
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero   = all_zero & (nib[i] == 4'h0);
      lzb_vec[i] = all_zero & (i != 0);
    end

    dig_sel_d     = '0;
    dig_hex_d     = dig_hex_q;
    dig_blank_d   = 1'b1;
    frame_start_d = frame_begin;
    // Ready is held low through the transfer cycle and returns the cycle after.
    wr_ready_d    = ~pending_d & ~xfer;

    if (state_d == SHOW) begin
      dig_sel_d   = NUM_DIGITS'(1) << idx_d;
      dig_hex_d   = nib[idx_d];
      dig_blank_d = (LZB != 0) ? lzb_vec[idx_d] : 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      dig_sel_q     <= '0;
      dig_hex_q     <= 4'h0;
      dig_blank_q   <= 1'b1;
      frame_start_q <= 1'b0;
      wr_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      dig_sel_q     <= dig_sel_d;
      dig_hex_q     <= dig_hex_d;
      dig_blank_q   <= dig_blank_d;
      frame_start_q <= frame_start_d;
      wr_ready_q    <= wr_ready_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl (NUM_DIGITS=4, DWELL_CYCLES=4, GAP_CYCLES=2, LZB=1).
// Expected output records are queued as stimulus is planned and popped one per cycle.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned DWELL = 4;
  localparam int unsigned GAPC  = 2;
  localparam int unsigned FRAME = ND * (DWELL + GAPC);
  localparam int unsigned NV    = 7;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] hex;
    logic       blank;
    logic       fs;
    logic       rdy;
  } exp_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  blank_mask;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        wr_valid;
  logic [15:0] value_in;
  logic        wr_ready;
  logic [3:0]  dig_hex;
  logic        dig_blank;
  logic [3:0]  dig_sel;
  logic        frame_start;

  exp_t sb[$];
  vec_t tbl [NV];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWELL),
    .GAP_CYCLES  (GAPC),
    .LZB         (1)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .en         (en),
    .wr_valid   (wr_valid),
    .value_in   (value_in),
    .wr_ready   (wr_ready),
    .dig_hex    (dig_hex),
    .dig_blank  (dig_blank),
    .dig_sel    (dig_sel),
    .frame_start(frame_start)
  );

  // Queue n cycles of a frame showing v; rm gives expected wr_ready per frame cycle.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] m,
                            input logic [23:0] rm, input int n);
    exp_t e;
    int   c = 0;
    for (int d = 0; d < int'(ND); d++) begin
      for (int k = 0; k < int'(DWELL + GAPC); k++) begin
        if (c < n) begin
          e.hex = v[4*d +: 4];
          e.rdy = rm[c];
          if (k < int'(DWELL)) begin
            e.sel   = 4'(1 << d);
            e.blank = m[d];
            e.fs    = (d == 0 && k == 0);
          end else begin
            e.sel   = 4'b0000;
            e.blank = 1'b1;
            e.fs    = 1'b0;
          end
          sb.push_back(e);
        end
        c++;
      end
    end
  endtask

  task automatic push_idle(input logic [3:0] hex, input logic rdy, input int n);
    exp_t e;
    e.sel   = 4'b0000;
    e.hex   = hex;
    e.blank = 1'b1;
    e.fs    = 1'b0;
    e.rdy   = rdy;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Advance to the next falling edge and compare the DUT against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({dig_sel, dig_hex, dig_blank, frame_start, wr_ready} !==
          {e.sel, e.hex, e.blank, e.fs, e.rdy}) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got sel=%b hex=%h blank=%b fs=%b rdy=%b, want sel=%b hex=%h blank=%b fs=%b rdy=%b",
                 cyc, dig_sel, dig_hex, dig_blank, frame_start, wr_ready,
                 e.sel, e.hex, e.blank, e.fs, e.rdy);
      end
    end
  endtask

  initial begin
    logic [23:0] rm;
    logic [15:0] v;

    tbl[0] = '{16'h1234, 4'b0000};
    tbl[1] = '{16'hABCD, 4'b0000};
    tbl[2] = '{16'h0050, 4'b1100};
    tbl[3] = '{16'h0000, 4'b1110};
    tbl[4] = '{16'h0100, 4'b1000};
    tbl[5] = '{16'hF00F, 4'b0000};
    tbl[6] = '{16'h0900, 4'b1000};

    reset    = 1'b1;
    en       = 1'b0;
    wr_valid = 1'b0;
    value_in = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    push_idle(4'h0, 1'b1, 20);
    repeat (20) tick();

    // Write while idle: ready drops, transfer happens in IDLE, ready returns after.
    wr_valid = 1'b1;
    value_in = tbl[0].value;
    push_idle(4'h0, 1'b0, 2);
    push_idle(4'h0, 1'b1, 1);
    tick();
    wr_valid = 1'b0;
    tick();
    tick();

    // Consecutive frames, each carrying a mid-frame write of the next table value.
    en = 1'b1;
    for (int k = 0; k < int'(NV); k++) begin
      rm = (k == 0) ? 24'hFFFFFF : 24'hFFFFFE;
      if (k < int'(NV) - 1) rm = rm & 24'h00001F;
      push_frame(tbl[k].value, tbl[k].blank_mask, rm, int'(FRAME));
      for (int c = 0; c < int'(FRAME); c++) begin
        tick();
        if (c == 4 && k < int'(NV) - 1) begin
          wr_valid = 1'b1;
          value_in = tbl[k+1].value;
        end
        if (c == 5) wr_valid = 1'b0;
      end
    end

    // en drops during digit 2 dwell: digit 2 and its gap complete, then idle.
    v = tbl[NV-1].value;
    push_frame(v, tbl[NV-1].blank_mask, 24'hFFFFFF, 18);
    push_idle(v[11:8], 1'b1, 8);
    for (int c = 0; c < 26; c++) begin
      tick();
      if (c == 12) en = 1'b0;
    end

    // Reset during SHOW with a pending write; the pending value must be discarded.
    en = 1'b1;
    push_frame(v, tbl[NV-1].blank_mask, 24'h000007, 7);
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 2) begin
        wr_valid = 1'b1;
        value_in = 16'h1234;
      end
      if (c == 3) wr_valid = 1'b0;
    end
    reset    = 1'b1;
    en       = 1'b0;
    wr_valid = 1'b0;
    push_idle(4'h0, 1'b1, 1);
    tick();
    reset = 1'b0;
    push_idle(4'h0, 1'b1, 3);
    repeat (3) tick();
    en = 1'b1;
    push_frame(16'h0000, 4'b1110, 24'hFFFFFF, int'(FRAME));
    repeat (FRAME) tick();
    en = 1'b0;

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
